seg_display: RTL
================

Name: seg_display

Overview:
- CPU-writable output peripheral driving an 8-digit multiplexed, common-anode seven-segment display.
- It is the output-direction counterpart to the board's key/switch input device.
- The CPU writes a 32-bit value (one hex nibble per digit) and a control word over the simple peripheral bus (Addr/We/Wd/Rd).
- The block time-multiplexes the digits with a free-running scan counter.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays selected (>= 2); bench uses 4.

Ports:
- Clk  input  1  system clock; all state updates on posedge Clk.
- Reset  input  1  synchronous, active-high reset.
- Addr  input  1  register select: 0 = DATA, 1 = CTRL.
- We  input  1  write enable; Wd is written to the register selected by Addr at posedge Clk.
- Wd  input  32  write data.
- Rd  output  32  read data, combinational from Addr.
- Seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
- Sel  output  8  active-low digit selects, bit i = digit i, registered.

Behaviour:
- Registers
  - DATA[31:0]: digit i shows nibble DATA[4i+3:4i].
  - CTRL[7:0] = digit enable mask; CTRL[15:8] = decimal-point enable per digit; CTRL[31:16] are not stored.
- Reset (synchronous, overrides everything in the same cycle)
  - DATA = 0, CTRL = 32'h000000FF, div = 0, idx = 0.
  - Sel = 8'hFF, Seg = 8'hFF (display dark).
- Read
  - Rd = DATA when Addr = 0; Rd = {16'b0, CTRL[15:0]} when Addr = 1.
  - A write is visible on Rd the cycle after the We edge.
- Scan counter
  - div counts 0..SCAN_DIV-1.
  - When div == SCAN_DIV-1: div -> 0 and idx -> idx+1, with idx wrapping 7 -> 0.
  - The counter free-runs regardless of We.
- Output register, updated every cycle from the current (pre-edge) idx/DATA/CTRL:
  - Sel <= CTRL[idx] ? ~(8'b1 << idx) : 8'hFF.
  - Seg[6:0] <= hex decode of the nibble at idx.
  - Seg[7] <= ~CTRL[8+idx].
  - When the digit is disabled, Seg <= 8'hFF as well.
- Latency
  - An idx change, or a write to DATA/CTRL, appears on Seg/Sel exactly one cycle later.
  - Sel never asserts more than one bit.
- Decode table (Seg with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
- Simultaneous events
  - A write in the same cycle as a scan step: both take effect. The register updates and idx advances; outputs use the old values that cycle and the new values the next.
- Reset mid-scan
  - Aborts the scan immediately: idx = 0, div = 0.
  - Outputs go dark for one cycle, then digit 0 is driven with DATA = 0 ("0" = C0, Sel = FE).

Test Plan:
- Reset -> cycle after Reset: Sel = FF, Seg = FF, Rd(Addr 0) = 0, Rd(Addr 1) = 000000FF; next cycle Sel = FE, Seg = C0.
- SCAN_DIV=4, write DATA = 12345678 -> Rd(Addr 0) = 12345678 next cycle; digits appear in order idx 0..7 for 4 cycles each: (FE,80), (FD,F8), (FB,82), (F7,92), (EF,99), (DF,B0), (BF,A4), (7F,F9); then wraps to (FE,80).
- Write CTRL = 0x000001FD with DATA = 0 -> digit 1 period: Sel = FF, Seg = FF; digit 0 period: Seg = 40 (dp lit); Rd(Addr 1) = 000001FD.
- Write CTRL = 0xABCD00F0 -> Rd(Addr 1) = 000000F0; digits 0-3 dark, digit 4 shows Sel = EF.
- Write DATA = FFFFFFFF on the same edge as a scan step from idx 2 -> 3 -> that cycle's output reflects idx 2 with the old data; the next cycle gives Sel = F7, Seg = 8E.
- Reset asserted during digit 5 -> one dark cycle (FF/FF), then Sel = FE, Seg = C0, and div restarts at 0 (digit 0 held for 4 cycles).

Source files
------------

// File: rtl/seg_display_if.sv
// seg_display_if: simple peripheral bus (Addr/We/Wd/Rd) between CPU and display block
interface seg_display_if;
  logic        Addr;
  logic        We;
  logic [31:0] Wd;
  logic [31:0] Rd;
  modport master (output Addr, We, Wd, input Rd);
  modport slave  (input Addr, We, Wd, output Rd);
endinterface

// File: rtl/seg_display.sv
// seg_display: CPU-writable 8-digit multiplexed common-anode seven-segment driver
module seg_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                Clk,
  input  logic                Reset,
  seg_display_if.slave        bus,
  output logic [7:0]          Seg,
  output logic [7:0]          Sel
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  logic [31:0]   data_q, data_d;
  logic [15:0]   ctrl_q, ctrl_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d, sel_q, sel_d;
  logic [3:0]    nib;
  logic          en, last;
  // active-low a..g pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction
  always_comb begin
    data_d = (bus.We && !bus.Addr) ? bus.Wd : data_q;
    ctrl_d = (bus.We && bus.Addr) ? bus.Wd[15:0] : ctrl_q;
    last   = div_q == DIV_LAST;
    div_d  = last ? '0 : div_q + 1'b1;
    idx_d  = last ? idx_q + 3'd1 : idx_q;
    nib    = data_q[{idx_q, 2'b00} +: 4];
    en     = ctrl_q[idx_q];
    sel_d  = en ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d  = en ? {~ctrl_q[{1'b1, idx_q}], hex7(nib)} : 8'hFF;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q <= '0;
      ctrl_q <= 16'h00FF;
      div_q  <= '0;
      idx_q  <= '0;
      seg_q  <= 8'hFF;
      sel_q  <= 8'hFF;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
    end
  end
  assign bus.Rd = bus.Addr ? {16'b0, ctrl_q} : data_q;
  assign Seg    = seg_q;
  assign Sel    = sel_q;
endmodule
